// File: rtl/note_sequencer.sv
// Melody sequencer: walks a synchronous note ROM and holds each note on fullnote
// for duration x TICK_DIV cycles, with start/stop, terminator and loop support.
module note_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 4194304
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [13:0]       rom_data,
  output logic [7:0]        fullnote,
  output logic              note_strobe,
  output logic              busy,
  output logic              song_done
);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, PLAY} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [7:0]        note_nx;
  logic              strobe_nx, done_nx;
  logic [PRE_W-1:0]  pre, pre_nx;
  logic [7:0]        beat, beat_nx;
  logic [7:0]        dur;

  assign dur = rom_data[13:6];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_addr    <= '0;
      fullnote    <= '0;
      note_strobe <= 1'b0;
      busy        <= 1'b0;
      song_done   <= 1'b0;
      pre         <= '0;
      beat        <= '0;
    end else begin
      state       <= state_nx;
      rom_addr    <= addr_nx;
      fullnote    <= note_nx;
      note_strobe <= strobe_nx;
      busy        <= (state_nx != IDLE);
      song_done   <= done_nx;
      pre         <= pre_nx;
      beat        <= beat_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = rom_addr;
    note_nx   = fullnote;
    strobe_nx = 1'b0;
    done_nx   = 1'b0;
    pre_nx    = pre;
    beat_nx   = beat;
    if (stop) begin
      state_nx = IDLE;
      note_nx  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          note_nx = '0;
          if (start) begin
            state_nx = WAIT;
            addr_nx  = '0;
          end
        end
        WAIT: state_nx = LOAD;
        LOAD: begin
          if (dur != 8'd0) begin
            note_nx   = {2'b00, rom_data[5:0]};
            strobe_nx = 1'b1;
            beat_nx   = dur;
            pre_nx    = PRE_MAX;
            addr_nx   = rom_addr + 1'b1;  // prefetch next entry while playing
            state_nx  = PLAY;
          end else begin
            note_nx = '0;
            done_nx = 1'b1;
            if (loop_en) begin
              addr_nx  = '0;
              state_nx = WAIT;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        PLAY: begin
          if (pre == '0) begin
            pre_nx  = PRE_MAX;
            beat_nx = beat - 8'd1;
          end else begin
            pre_nx = pre - PRE_ONE;
          end
          // Leaving one cycle early lets the LOAD cycle complete the last tick.
          if (beat == 8'd1 && pre == PRE_ONE) state_nx = LOAD;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: timeline model built from ROM contents, checked every
// cycle, plus literal checks and a second small-address instance for address wrap.
module tb_note_sequencer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, loop_en;
  logic [7:0]  rom_addr, fullnote;
  logic [13:0] rom_data;
  logic        note_strobe, busy, song_done;

  logic        start_w, stop_w, loop_w;
  logic [1:0]  rom_addr_w;
  logic [7:0]  fullnote_w;
  logic [13:0] rom_data_w;
  logic        note_strobe_w, busy_w, song_done_w;

  logic [13:0] rom [256];
  logic [13:0] rom_w [4];

  always #5 clk = ~clk;

  note_sequencer #(.ADDR_W(8), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .fullnote(fullnote),
    .note_strobe(note_strobe), .busy(busy), .song_done(song_done));

  note_sequencer #(.ADDR_W(2), .TICK_DIV(TD)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .stop(stop_w), .loop_en(loop_w),
    .rom_addr(rom_addr_w), .rom_data(rom_data_w), .fullnote(fullnote_w),
    .note_strobe(note_strobe_w), .busy(busy_w), .song_done(song_done_w));

  always @(posedge clk) rom_data   <= rom[rom_addr];
  always @(posedge clk) rom_data_w <= rom_w[rom_addr_w];

  int n_chk = 0, n_pass = 0, n_strobe = 0, n_done = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  // Expected per-cycle view of the outputs, generated from the ROM contents.
  typedef struct packed {
    logic [7:0] fn; logic st; logic dn; logic by; logic [7:0] ad;
  } exp_t;
  exp_t q[$];
  exp_t cur;

  function automatic exp_t mk(input logic [7:0] fn, input logic st, input logic dn,
                              input logic by, input logic [7:0] ad);
    exp_t e;
    e.fn = fn; e.st = st; e.dn = dn; e.by = by; e.ad = ad;
    return e;
  endfunction

  task automatic build_pass(input int prefix);
    for (int p = 0; p < prefix; p++) q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b1, 8'd0));
    for (int i = 0; i < 256; i++) begin
      int d;
      d = int'(rom[i][13:6]);
      if (d == 0) begin
        q.push_back(mk(8'd0, 1'b0, 1'b1, loop_en, loop_en ? 8'd0 : 8'(i)));
        return;
      end
      for (int c = 0; c < d * TD; c++)
        q.push_back(mk({2'b00, rom[i][5:0]}, c == 0, 1'b0, 1'b1, 8'(i + 1)));
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete(); cur = mk(8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    end else if (stop) begin
      q.delete(); cur = mk(8'd0, 1'b0, 1'b0, 1'b0, cur.ad);
    end else if (start && !cur.by) begin
      q.delete(); build_pass(2); cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
      if (cur.dn && cur.by) build_pass(1);
    end else begin
      cur = mk(8'd0, 1'b0, 1'b0, 1'b0, cur.ad);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fullnote", 32'(fullnote), 32'(cur.fn));
      chk("note_strobe", 32'(note_strobe), 32'(cur.st));
      chk("song_done", 32'(song_done), 32'(cur.dn));
      chk("busy", 32'(busy), 32'(cur.by));
      chk("rom_addr", 32'(rom_addr), 32'(cur.ad));
      if (note_strobe) n_strobe++;
      if (song_done) n_done++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  int wnote[4] = '{20, 22, 23, 25};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_w = 1'b0; stop_w = 1'b0; loop_w = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 14'd0;
    rom[0] = {8'd1, 6'd25}; rom[1] = {8'd2, 6'd27}; rom[2] = 14'd0;
    for (int i = 0; i < 4; i++) rom_w[i] = {8'd1, 6'(wnote[i])};
    cyc(2);
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("reset fullnote", 32'(fullnote), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rom_addr", 32'(rom_addr), 32'd0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("start+stop busy", 32'(busy), 32'd0);
    chk("start+stop rom_addr", 32'(rom_addr), 32'd0);
    cyc(2);

    // single pass, with an ignored start during note 27
    n_strobe = 0; n_done = 0;
    pulse_start();
    chk("start busy", 32'(busy), 32'd1);
    cyc(2);
    chk("first note", 32'(fullnote), 32'd25);
    chk("first strobe", 32'(note_strobe), 32'd1);
    cyc(4);
    chk("second note", 32'(fullnote), 32'd27);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(7);
    chk("end fullnote", 32'(fullnote), 32'd0);
    chk("end song_done", 32'(song_done), 32'd1);
    chk("end busy", 32'(busy), 32'd0);
    cyc(3);
    chk("strobe count", 32'(n_strobe), 32'd2);
    chk("done count", 32'(n_done), 32'd1);

    // looping
    loop_en = 1'b1; n_done = 0;
    pulse_start();
    cyc(14);
    chk("loop song_done", 32'(song_done), 32'd1);
    chk("loop busy", 32'(busy), 32'd1);
    cyc(2);
    chk("loop restart note", 32'(fullnote), 32'd25);
    cyc(28);
    chk("loop done count", 32'(n_done), 32'd3);
    stop = 1'b1; cyc(); stop = 1'b0; loop_en = 1'b0;
    cyc(2);

    // stop in third cycle of note 27
    n_done = 0;
    pulse_start();
    cyc(8);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop fullnote", 32'(fullnote), 32'd0);
    chk("stop busy", 32'(busy), 32'd0);
    cyc(3);
    chk("stop no done", 32'(n_done), 32'd0);
    pulse_start();
    cyc(2);
    chk("replay note", 32'(fullnote), 32'd25);
    cyc(16);

    // reset mid-note
    pulse_start();
    cyc(4);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rst fullnote", 32'(fullnote), 32'd0);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst strobe", 32'(note_strobe), 32'd0);
    pulse_start();
    cyc(2);
    chk("rst replay note", 32'(fullnote), 32'd25);
    cyc(16);

    // rest and top note value
    rom[0] = {8'd1, 6'd0}; rom[1] = {8'd2, 6'd63};
    pulse_start();
    cyc(2);
    chk("rest fullnote", 32'(fullnote), 32'd0);
    chk("rest strobe", 32'(note_strobe), 32'd1);
    cyc(4);
    chk("note 63", 32'(fullnote), 32'd63);
    cyc(10);

    // address wrap on the 2-bit instance: 20,22,23,25 repeat with no gap
    start_w = 1'b1; cyc(); start_w = 1'b0;
    for (int k = 0; k < 40; k++) begin
      chk("wrap fullnote", 32'(fullnote_w), k < 2 ? 32'd0 : 32'(wnote[((k - 2) / 4) % 4]));
      chk("wrap strobe", 32'(note_strobe_w), 32'(k >= 2 && (k - 2) % 4 == 0));
      cyc();
    end
    stop_w = 1'b1; cyc(); stop_w = 1'b0;
    chk("wrap stop busy", 32'(busy_w), 32'd0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
